// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: streams a block from two read ports and
// accumulates per-lane |a-b|. Define SAD_EARLY_TERM_EN for threshold abort.

module sad_lane #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] d_o
);
  assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
endmodule

module sad_engine #(
  parameter int PIX_W     = 8,
  parameter int LANES     = 4,
  parameter int BLOCK_PIX = 256,
  parameter int ADDR_W    = 9,
  parameter int RD_LAT    = 1,
  parameter int SAD_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PIX_W*LANES-1:0] a_data,
  input  logic [PIX_W*LANES-1:0] b_data,
`ifdef SAD_EARLY_TERM_EN
  input  logic [SAD_W-1:0]       thresh,
  output logic                   aborted,
`endif
  output logic [ADDR_W-1:0]      ab_addr,
  output logic                   rd_en,
  output logic                   busy,
  output logic                   done,
  output logic [SAD_W-1:0]       sad
);
  localparam int WORDS  = BLOCK_PIX / LANES;
  localparam int TREE_W = PIX_W + $clog2(LANES);

  if (BLOCK_PIX % LANES != 0) begin : g_chk_lanes
    $error("BLOCK_PIX must be a multiple of LANES");
  end
  if ((2 ** ADDR_W) < WORDS) begin : g_chk_addr
    $error("ADDR_W too small for WORDS");
  end
  if (RD_LAT < 1) begin : g_chk_lat
    $error("RD_LAT must be >= 1");
  end
  if (SAD_W < PIX_W + $clog2(BLOCK_PIX)) begin : g_chk_sad
    $error("SAD_W too small for BLOCK_PIX");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [RD_LAT:1]               vld_q, last_q;
  logic [RD_LAT:0]               vld_pipe, last_pipe;
  logic [LANES-1:0][PIX_W-1:0]   a_lane, b_lane, diff;
  logic [TREE_W-1:0]             tree_d, tree_q;
  logic                          s1_vld_q, s1_last_q;
  logic [SAD_W-1:0]              acc_q, acc_sum, sad_q;
  logic                          aborted_q;
  logic                          last_issue, term, clr, load_sad;

  assign a_lane = a_data;
  assign b_lane = b_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sad_lane #(.PIX_W(PIX_W)) u_lane (.a_i(a_lane[g]), .b_i(b_lane[g]), .d_o(diff[g]));
  end

  always_comb begin
    tree_d = '0;
    for (int i = 0; i < LANES; i++) tree_d = tree_d + TREE_W'(diff[i]);
  end

  assign acc_sum    = acc_q + SAD_W'(tree_q);
  assign last_issue = (state_q == RUN) && (addr_q == ADDR_W'(WORDS - 1));

`ifdef SAD_EARLY_TERM_EN
  assign term = ((state_q == RUN) || (state_q == DRAIN)) && (acc_q > thresh);
`else
  assign term = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE:  if (start) begin state_d = RUN; addr_d = '0; end
      RUN: begin
        rd_en = 1'b1;
        if (last_issue) state_d = DRAIN;
        else            addr_d  = addr_q + ADDR_W'(1);
      end
      DRAIN: if (s1_vld_q && s1_last_q) state_d = DONE;
      DONE: begin
        if (start) begin state_d = RUN; addr_d = '0; end
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything: stop issuing and report on the next cycle.
    if (term) begin
      state_d = DONE;
      addr_d  = addr_q;
      rd_en   = 1'b0;
    end
  end

  assign vld_pipe  = {vld_q, rd_en};
  assign last_pipe = {last_q, rd_en && last_issue};
  assign clr       = (state_d == RUN) && (state_q != RUN);
  assign load_sad  = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      vld_q     <= '0;
      last_q    <= '0;
      tree_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      acc_q     <= '0;
      sad_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      vld_q     <= term ? '0 : vld_pipe[RD_LAT-1:0];
      last_q    <= term ? '0 : last_pipe[RD_LAT-1:0];
      tree_q    <= tree_d;
      s1_vld_q  <= vld_pipe[RD_LAT] && !term;
      s1_last_q <= last_pipe[RD_LAT] && !term;
      if (clr)                      acc_q <= '0;
      else if (s1_vld_q && !term)   acc_q <= acc_sum;
      if (load_sad) begin
        sad_q     <= term ? acc_q : acc_sum;
        aborted_q <= term;
      end
    end
  end

  assign ab_addr = addr_q;
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign sad     = sad_q;
`ifdef SAD_EARLY_TERM_EN
  assign aborted = aborted_q;
`endif

endmodule
